// File: rtl/pc_select.sv
// pc_select: Y86-64 front-end PC selection and fetch-state register.
// Holds the predicted next PC, applies M-stage mispredict and W-stage ret
// corrections combinationally, predicts jump/call successors, and runs a
// small RUN/HALTED machine that freezes supply on halt, invalid or imem error.
// Optional feature macro: PC_BTFNT_EN (backward-taken/forward-not-taken
// prediction for conditional jumps; when undefined every jump is predicted taken).
module pc_select #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        F_stall_i,
    input  logic [3:0]  f_icode_i,
    input  logic [3:0]  f_ifun_i,
    input  logic [63:0] f_valC_i,
    input  logic [63:0] f_valP_i,
    input  logic        f_instr_valid_i,
    input  logic        f_imem_error_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic        M_pred_taken_i,
    input  logic [63:0] M_valC_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    output logic [63:0] PC_o,
    output logic        f_pred_taken_o,
    output logic [63:0] predPC_o,
    output logic [2:0]  stat_o,
    output logic        halted_o
);

    typedef enum logic [3:0] {
        I_HALT = 4'h0,
        I_JXX  = 4'h7,
        I_CALL = 4'h8,
        I_RET  = 4'h9
    } icode_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t      state;
    stat_t       stat;
    logic [63:0] pred_pc;

    logic        mispredict;
    logic        ret_fix;
    logic        correction;
    logic        pred_taken;
    logic [63:0] next_pc;
    logic        stop;
    stat_t       cause;

    // Correction detection, PC mux and successor prediction.
    always_comb begin
        mispredict = (M_icode_i == I_JXX) && (M_cnd_i != M_pred_taken_i);
        ret_fix    = (W_icode_i == I_RET);
        correction = mispredict || ret_fix;

        if (rst_i)
            PC_o = RESET_PC;
        else if (mispredict)
            PC_o = M_cnd_i ? M_valC_i : M_valA_i;
        else if (ret_fix)
            PC_o = W_valM_i;
        else
            PC_o = pred_pc;

        pred_taken = 1'b0;
        if (f_icode_i == I_JXX) begin
            if (f_ifun_i == 4'h0)
                pred_taken = 1'b1;
            else begin
`ifdef PC_BTFNT_EN
                pred_taken = (f_valC_i < f_valP_i);
`else
                pred_taken = 1'b1;
`endif
            end
        end
        f_pred_taken_o = rst_i ? 1'b0 : pred_taken;

        if ((f_icode_i == I_CALL) || ((f_icode_i == I_JXX) && pred_taken))
            next_pc = f_valC_i;
        else
            next_pc = f_valP_i;

        stop = f_imem_error_i || !f_instr_valid_i || (f_icode_i == I_HALT);
        if (f_imem_error_i)
            cause = STAT_ADR;
        else if (!f_instr_valid_i)
            cause = STAT_INS;
        else
            cause = STAT_HLT;
    end

    // Run/halt state machine with predicted PC and status registers.
    // In HALTED a correction re-evaluates the corrected fetch exactly like
    // RUN does, so a stopping corrected fetch re-halts with its own cause.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_RUN;
            stat    <= STAT_AOK;
            pred_pc <= RESET_PC;
        end else if (!F_stall_i && ((state == S_RUN) || correction)) begin
            if (stop) begin
                state   <= S_HALTED;
                stat    <= cause;
                pred_pc <= PC_o;
            end else begin
                state   <= S_RUN;
                stat    <= STAT_AOK;
                pred_pc <= next_pc;
            end
        end
    end

    assign predPC_o = pred_pc;
    assign stat_o   = stat;
    assign halted_o = (state == S_HALTED);

endmodule

// File: tb/tb_pc_select.sv
// tb_pc_select: directed self-checking bench for pc_select.
// Honours PC_BTFNT_EN for the conditional-jump prediction expectations.
module tb_pc_select;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        F_stall_i;
    logic [3:0]  f_icode_i;
    logic [3:0]  f_ifun_i;
    logic [63:0] f_valC_i;
    logic [63:0] f_valP_i;
    logic        f_instr_valid_i;
    logic        f_imem_error_i;
    logic [3:0]  M_icode_i;
    logic        M_cnd_i;
    logic        M_pred_taken_i;
    logic [63:0] M_valC_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic [63:0] PC_o;
    logic        f_pred_taken_o;
    logic [63:0] predPC_o;
    logic [2:0]  stat_o;
    logic        halted_o;

    int checks = 0;
    int errors = 0;
    logic exp_pred;
    logic [63:0] exp_pc;

    pc_select #(.RESET_PC(64'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .F_stall_i(F_stall_i),
        .f_icode_i(f_icode_i), .f_ifun_i(f_ifun_i), .f_valC_i(f_valC_i),
        .f_valP_i(f_valP_i), .f_instr_valid_i(f_instr_valid_i),
        .f_imem_error_i(f_imem_error_i), .M_icode_i(M_icode_i),
        .M_cnd_i(M_cnd_i), .M_pred_taken_i(M_pred_taken_i),
        .M_valC_i(M_valC_i), .M_valA_i(M_valA_i), .W_icode_i(W_icode_i),
        .W_valM_i(W_valM_i), .PC_o(PC_o), .f_pred_taken_o(f_pred_taken_o),
        .predPC_o(predPC_o), .stat_o(stat_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_mw();
        M_icode_i = 4'h1; M_cnd_i = 1'b0; M_pred_taken_i = 1'b0;
        M_valC_i = '0; M_valA_i = '0;
        W_icode_i = 4'h1; W_valM_i = '0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_icode_i = ic; f_ifun_i = fn; f_valC_i = vc; f_valP_i = vp;
        f_instr_valid_i = 1'b1; f_imem_error_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; F_stall_i = 1'b0;
        idle_mw();
        fetch(4'h7, 4'h0, 64'h5, 64'h9);
        // Correction inputs must not leak through while reset is held.
        M_icode_i = 4'h7; M_cnd_i = 1'b1; M_pred_taken_i = 1'b0; M_valC_i = 64'h999;
        tick(); tick();
        chk("rst_pc", PC_o, 64'h0);
        chk("rst_pred", {63'b0, f_pred_taken_o}, 64'h0);
        chk("rst_predpc", predPC_o, 64'h0);
        chk("rst_stat", {61'b0, stat_o}, 64'd1);
        chk("rst_halted", {63'b0, halted_o}, 64'h0);
        idle_mw();
        rst_i = 1'b0;

        // Three sequential irmovq.
        fetch(4'h3, 4'h0, 64'h0, 64'd10); #1;
        chk("seq_pc0", PC_o, 64'd0);
        tick();
        fetch(4'h3, 4'h0, 64'h0, 64'd20); #1;
        chk("seq_pc10", PC_o, 64'd10);
        tick();
        fetch(4'h3, 4'h0, 64'h0, 64'd30); #1;
        chk("seq_pc20", PC_o, 64'd20);
        chk("seq_stat", {61'b0, stat_o}, 64'd1);
        tick();

        // jmp at 30 to 96: unconditional is always predicted taken.
        fetch(4'h7, 4'h0, 64'd96, 64'd39); #1;
        chk("jmp_pred", {63'b0, f_pred_taken_o}, 64'd1);
        tick();
        chk("jmp_pc", PC_o, 64'd96);

        // call at 96.
        fetch(4'h8, 4'h0, 64'h80, 64'd105); #1;
        chk("call_pred", {63'b0, f_pred_taken_o}, 64'd0);
        tick();
        chk("call_pc", PC_o, 64'h80);
        chk("call_predpc", predPC_o, 64'h80);

        // ret in W overrides predicted PC in the same cycle.
        W_icode_i = 4'h9; W_valM_i = 64'd105;
        fetch(4'h7, 4'h0, 64'd82, 64'd114); #1;
        chk("ret_pc", PC_o, 64'd105);
        tick();
        idle_mw(); #1;
        chk("ret_next_pc", PC_o, 64'd82);

        // Conditional jg at 82, forward target.
`ifdef PC_BTFNT_EN
        exp_pred = 1'b0; exp_pc = 64'd91;
`else
        exp_pred = 1'b1; exp_pc = 64'h60;
`endif
        fetch(4'h7, 4'h6, 64'h60, 64'd91); #1;
        chk("jg_pred", {63'b0, f_pred_taken_o}, {63'b0, exp_pred});
        tick();
        chk("jg_next_pc", PC_o, exp_pc);

        // Mispredict resolves in M while a ret sits in W: M wins.
        M_icode_i = 4'h7; M_cnd_i = ~exp_pred; M_pred_taken_i = exp_pred;
        M_valC_i = 64'h60; M_valA_i = 64'd91;
        W_icode_i = 4'h9; W_valM_i = 64'h777;
        fetch(4'h7, 4'h0, 64'd129, 64'd200); #1;
        chk("misp_pc", PC_o, exp_pred ? 64'd91 : 64'h60);
        tick();
        idle_mw(); #1;
        chk("misp_next_pc", PC_o, 64'd129);

        // halt at 129.
        fetch(4'h0, 4'h0, 64'h0, 64'd130); #1;
        tick();
        chk("hlt_stat", {61'b0, stat_o}, 64'd2);
        chk("hlt_halted", {63'b0, halted_o}, 64'd1);
        chk("hlt_pc", PC_o, 64'd129);
        tick();
        chk("hlt_hold_predpc", predPC_o, 64'd129);
        chk("hlt_hold_stat", {61'b0, stat_o}, 64'd2);

        // Wrong-path halt cleared by a mispredict.
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_pred_taken_i = 1'b1;
        M_valC_i = 64'h60; M_valA_i = 64'd200;
        fetch(4'h1, 4'h0, 64'h0, 64'd210); #1;
        chk("unhalt_pc", PC_o, 64'd200);
        chk("unhalt_still_halted", {63'b0, halted_o}, 64'd1);
        tick();
        idle_mw(); #1;
        chk("unhalt_halted", {63'b0, halted_o}, 64'd0);
        chk("unhalt_stat", {61'b0, stat_o}, 64'd1);
        chk("unhalt_pc_next", PC_o, 64'd210);

        // jmp to 1030, then imem error + invalid under stall.
        fetch(4'h7, 4'h0, 64'd1030, 64'd219);
        tick();
        chk("jmp1030_pc", PC_o, 64'd1030);
        fetch(4'h1, 4'h0, 64'h0, 64'd1031);
        f_imem_error_i = 1'b1; f_instr_valid_i = 1'b0;
        F_stall_i = 1'b1;
        tick();
        chk("stall_halted", {63'b0, halted_o}, 64'd0);
        chk("stall_stat", {61'b0, stat_o}, 64'd1);
        chk("stall_predpc", predPC_o, 64'd1030);
        F_stall_i = 1'b0;
        tick();
        chk("adr_stat", {61'b0, stat_o}, 64'd3);
        chk("adr_halted", {63'b0, halted_o}, 64'd1);
        chk("adr_predpc", predPC_o, 64'd1030);

        // Stall overrides a correction while halted.
        W_icode_i = 4'h9; W_valM_i = 64'd300;
        fetch(4'h1, 4'h0, 64'h0, 64'd301);
        f_instr_valid_i = 1'b0;
        F_stall_i = 1'b1; #1;
        chk("ret_fix_pc_halted", PC_o, 64'd300);
        tick();
        chk("stallfix_stat", {61'b0, stat_o}, 64'd3);
        chk("stallfix_predpc", predPC_o, 64'd1030);
        // Corrected fetch is itself invalid: re-halt with INS.
        F_stall_i = 1'b0;
        tick();
        idle_mw();
        chk("ins_stat", {61'b0, stat_o}, 64'd4);
        chk("ins_halted", {63'b0, halted_o}, 64'd1);
        chk("ins_predpc", predPC_o, 64'd300);

        // Reset while halted.
        rst_i = 1'b1;
        tick();
        chk("rst2_stat", {61'b0, stat_o}, 64'd1);
        chk("rst2_halted", {63'b0, halted_o}, 64'd0);
        chk("rst2_predpc", predPC_o, 64'd0);
        rst_i = 1'b0;

        // Backward conditional jump is predicted taken in both builds.
        fetch(4'h7, 4'h4, 64'h0, 64'd9); #1;
        chk("back_pred", {63'b0, f_pred_taken_o}, 64'd1);
        tick();
        chk("back_pc", PC_o, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_select.md
# pc_select

Front-end PC-selection and fetch-state register for the Y86-64 pipeline. It sits directly upstream of the fetch stage and drives the 64-bit PC that fetch decodes each cycle. It holds the predicted next PC, applies branch-mispredict and `ret` corrections from the M and W stages, and predicts the successor of jumps and calls. A small run/halt state machine freezes instruction supply on `halt`, an invalid instruction or an imem error, and records the cause as a status code.

## Interface
Parameters:
- `RESET_PC`, default 64'h0, PC fetched first after reset.

Ports:
- `clk_i`  in  1  clock; all state updates on posedge.
- `rst_i`  in  1  synchronous reset, active-high.
- `F_stall_i`  in  1  hold all state this cycle.
- `f_icode_i`  in  4  icode from fetch for current `PC_o`.
- `f_ifun_i`  in  4  ifun from fetch.
- `f_valC_i`  in  64  immediate from fetch.
- `f_valP_i`  in  64  fall-through address from fetch.
- `f_instr_valid_i`  in  1  fetch instruction-valid flag.
- `f_imem_error_i`  in  1  fetch out-of-range flag.
- `M_icode_i`  in  4  icode in M stage.
- `M_cnd_i`  in  1  condition result of the jump in M.
- `M_pred_taken_i`  in  1  prediction carried down with the jump in M.
- `M_valC_i`  in  64  jump target of the jump in M.
- `M_valA_i`  in  64  fall-through address of the jump in M.
- `W_icode_i`  in  4  icode in W stage.
- `W_valM_i`  in  64  return address popped by `ret` in W.
- `PC_o`  out  64  address fetch reads this cycle (combinational).
- `f_pred_taken_o`  out  1  prediction for the current fetched jump; piped downstream.
- `predPC_o`  out  64  registered predicted PC.
- `stat_o`  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- `halted_o`  out  1  state machine is in HALTED.

## Operation
- icodes used: HALT=0, JXX=7, CALL=8, RET=9.
- Correction selects:
  - `mispredict` = (M_icode==JXX) && (M_cnd != M_pred_taken).
  - `ret_fix` = (W_icode==RET).
- PC select, in priority order:
  - `mispredict`: PC_o = M_cnd ? M_valC : M_valA.
  - else `ret_fix`: PC_o = W_valM.
  - else PC_o = predPC.
- Prediction `f_pred_taken_o`:
  - JXX with ifun 0: always 1.
  - Other JXX: per Configuration.
  - Non-JXX: 0.
- Next predPC:
  - CALL: valC.
  - JXX predicted taken: valC.
  - Otherwise: valP.
- Stop condition `stop` = f_imem_error || !f_instr_valid || f_icode==HALT.
- Stop cause, by priority: ADR, then INS, then HLT.
- State RUN:
  - At posedge with !F_stall and !stop: predPC <= next predPC.
  - At posedge with !F_stall and stop: predPC <= PC_o (freezes on the stopping instruction), stat <= cause, state <= HALTED.
- State HALTED:
  - predPC and stat hold; PC_o = predPC unless a correction is active.
  - At posedge with !F_stall and an active correction: state <= RUN, stat <= AOK, predPC <= next predPC of the corrected fetch. The stop came from a wrong path.
  - If that corrected fetch itself stops, it re-enters HALTED with the new cause.
- `F_stall_i` high: no register changes. Stall overrides a simultaneous correction or stop.
- All adds and compares are unsigned 64-bit. valP/valC are taken verbatim, with no wrap checks.

## Timing
- Reset values: predPC=RESET_PC, state=RUN, stat_o=1, halted_o=0.
- While `rst_i` is high, PC_o = RESET_PC and f_pred_taken_o=0, regardless of M/W inputs.
- Reset asserted mid-HALTED or mid-stall returns to the reset values on the next posedge.
- PC_o and f_pred_taken_o are combinational from the registers and current inputs: zero-cycle correction.
- predPC_o, stat_o and halted_o are registered and change only on posedge.
- Next-instruction latency: the fetch result at cycle n sets PC_o at cycle n+1.

## Configuration
- `PC_BTFNT_EN` defined: conditional JXX is predicted taken iff valC < valP (backward taken, forward not taken).
- Undefined: every JXX is predicted taken.
- The mispredict rule is unchanged either way, because it uses `M_pred_taken_i`.

## Test plan
- Reset, then 3 sequential 10-byte irmovq at 0, 10, 20 → PC_o = 0, 10, 20 on successive cycles; stat_o=1.
- Fetch `call` at 96 with valC=0x80 → next PC_o=0x80. Later, W_icode=9 and W_valM=105 with no M correction → PC_o=105 that cycle.
- Conditional jg at 82, valC=0x60, valP=91. Undefined macro: pred=1, next PC_o=0x60; then M_icode=7, M_cnd=0, M_pred_taken=1, M_valA=91 → PC_o=91. Defined macro: pred=0, next PC_o=91.
- M mispredict and W ret in the same cycle → PC_o takes the M target.
- `halt` fetched at 129 → posedge: stat_o=2, halted_o=1, PC_o stays 129. Then a mispredict with M_valA=200 → PC_o=200 immediately; next posedge halted_o=0, stat_o=1.
- PC 1030 with f_imem_error=1 and f_instr_valid=0 → stat_o=3 (ADR beats INS). Stop with F_stall_i=1 → no state change until stall drops.
